// File: rtl/free_index_allocator_if.sv
// Port bundle for the free-index allocator: grant channel, release channel and status.
// The allocator takes the slave view; the slot owner or request logic takes the master view.
interface free_index_allocator_if #(
   parameter int NUM_ENTRIES = 8
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic             flush;
   logic             alloc_valid;
   logic [IDX_W-1:0] alloc_index;
   logic             alloc_ready;
   logic             free_valid;
   logic [IDX_W-1:0] free_index;
   logic [IDX_W:0]   free_count;
   logic             all_free;
   logic             free_err;

   modport master (
      output flush,
      output alloc_ready,
      output free_valid,
      output free_index,
      input  alloc_valid,
      input  alloc_index,
      input  free_count,
      input  all_free,
      input  free_err
   );

   modport slave (
      input  flush,
      input  alloc_ready,
      input  free_valid,
      input  free_index,
      output alloc_valid,
      output alloc_index,
      output free_count,
      output all_free,
      output free_err
   );
endinterface

// File: rtl/free_index_allocator.sv
// Owns the free/used bitmap of NUM_ENTRIES slots, offers one free index per cycle and
// accepts one release per cycle, with lowest-first or round-robin selection.
module free_index_allocator #(
   parameter int NUM_ENTRIES = 8,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   free_index_allocator_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] bitmap_r;
   logic [IDX_W-1:0]       rr_ptr_r;
   logic [CNT_W-1:0]       free_count_r;
   logic                   all_free_r;
   logic                   free_err_r;

   logic                   alloc_valid_s;
   logic                   pick_found_s;
   logic [IDX_W-1:0]       pick_idx_s;
   logic [CNT_W-1:0]       cand_s;
   logic                   grant_s;
   logic                   in_range_s;
   logic                   slot_used_s;
   logic                   rel_legal_s;
   logic                   rel_illegal_s;
   logic [CNT_W-1:0]       next_ptr_s;
   logic [NUM_ENTRIES-1:0] bitmap_n_s;
   logic [IDX_W-1:0]       rr_ptr_n_s;
   logic [CNT_W-1:0]       free_count_n_s;
   logic                   free_err_n_s;

   assign alloc_valid_s = |bitmap_r;
   assign grant_s       = alloc_valid_s & bus.alloc_ready;

   // Select the offered slot: scan starts at 0 (lowest-first) or at rr_ptr with wrap.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      cand_s       = '0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         if (ROUND_ROBIN != 0) begin
            cand_s = {1'b0, rr_ptr_r} + CNT_W'(k);
         end else begin
            cand_s = CNT_W'(k);
         end
         if (cand_s >= NUM_C) begin
            cand_s = cand_s - NUM_C;
         end else begin
            cand_s = cand_s;
         end
         if (!pick_found_s && bitmap_r[cand_s[IDX_W-1:0]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = cand_s[IDX_W-1:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Classify the release: only an in-range slot currently marked used may be returned.
   // A slot being granted this cycle is still free, so releasing it is illegal.
   always_comb begin
      in_range_s  = ({1'b0, bus.free_index} < NUM_C);
      slot_used_s = 1'b0;
      if (in_range_s) begin
         slot_used_s = ~bitmap_r[bus.free_index];
      end else begin
         slot_used_s = 1'b0;
      end
      rel_legal_s   = bus.free_valid & slot_used_s;
      rel_illegal_s = bus.free_valid & ~slot_used_s;
   end

   // Next-state computation; flush overrides both grant and release.
   always_comb begin
      bitmap_n_s     = bitmap_r;
      rr_ptr_n_s     = rr_ptr_r;
      free_count_n_s = free_count_r;
      free_err_n_s   = rel_illegal_s;
      next_ptr_s     = {1'b0, pick_idx_s} + CNT_W'(1);
      if (bus.flush) begin
         bitmap_n_s     = {NUM_ENTRIES{1'b1}};
         rr_ptr_n_s     = '0;
         free_count_n_s = NUM_C;
         free_err_n_s   = 1'b0;
      end else begin
         if (grant_s) begin
            bitmap_n_s[pick_idx_s] = 1'b0;
            if (next_ptr_s >= NUM_C) begin
               rr_ptr_n_s = '0;
            end else begin
               rr_ptr_n_s = next_ptr_s[IDX_W-1:0];
            end
         end else begin
            rr_ptr_n_s = rr_ptr_r;
         end
         // Grant and legal release always target different slots, so both can apply.
         if (rel_legal_s) begin
            bitmap_n_s[bus.free_index] = 1'b1;
         end else begin
            bitmap_n_s = bitmap_n_s;
         end
         case ({grant_s, rel_legal_s})
            2'b10:   free_count_n_s = free_count_r - CNT_W'(1);
            2'b01:   free_count_n_s = free_count_r + CNT_W'(1);
            default: free_count_n_s = free_count_r;
         endcase
      end
   end

   // State register with asynchronous reset to the all-free condition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_r     <= {NUM_ENTRIES{1'b1}};
         rr_ptr_r     <= '0;
         free_count_r <= NUM_C;
         all_free_r   <= 1'b1;
         free_err_r   <= 1'b0;
      end else begin
         bitmap_r     <= bitmap_n_s;
         rr_ptr_r     <= rr_ptr_n_s;
         free_count_r <= free_count_n_s;
         all_free_r   <= (free_count_n_s == NUM_C);
         free_err_r   <= free_err_n_s;
      end
   end

   assign bus.alloc_valid = alloc_valid_s;
   assign bus.alloc_index = pick_idx_s;
   assign bus.free_count  = free_count_r;
   assign bus.all_free    = all_free_r;
   assign bus.free_err    = free_err_r;

endmodule
